// File: rtl/prod_accum_16s.sv
// Purpose: sums blocks of COUNT signed 16-bit products into a saturating ACC_W accumulator.
// Latency: block sum is valid 1 cycle after the COUNT-th accepted product.
// Backpressure: prod_ready drops while a finished sum waits; prod_ready depends on state only.
module prod_accum_16s #(
  parameter int ACC_W = 24,
  parameter int COUNT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [15:0]      prod_in,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_sat,
  output logic             acc_valid,
  input  logic             acc_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [7:0]       COUNT_L = 8'(COUNT);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             acc_sat_q, acc_sat_d;
  logic             acc_valid_q, acc_valid_d;

  logic [ACC_W-1:0] prod_sext;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_sat;
  logic             sum_ovf;
  logic             accept;
  logic [7:0]       cnt_inc;

  assign prod_ready = (state_q != DONE);
  assign accept     = prod_valid && prod_ready;
  assign acc_out    = acc_out_q;
  assign acc_sat    = acc_sat_q;
  assign acc_valid  = acc_valid_q;

  // Add one extra bit of headroom, then clamp when the top two bits disagree.
  always_comb begin
    prod_sext = {{(ACC_W-16){prod_in[15]}}, prod_in};
    sum_ext   = {acc_q[ACC_W-1], acc_q} + {prod_sext[ACC_W-1], prod_sext};
    sum_ovf   = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    if (!sum_ovf) begin
      sum_sat = sum_ext[ACC_W-1:0];
    end else if (sum_ext[ACC_W]) begin
      sum_sat = ACC_MIN;
    end else begin
      sum_sat = ACC_MAX;
    end
  end

  // Next-state and output-register logic; clear overrides every state.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    acc_out_d   = acc_out_q;
    acc_sat_d   = acc_sat_q;
    acc_valid_d = acc_valid_q;
    cnt_inc     = cnt_q + 8'd1;

    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      sat_d       = 1'b0;
      acc_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (COUNT_L == 8'd1) begin
              // Single-product blocks finish immediately; a lone product cannot overflow.
              state_d     = DONE;
              acc_out_d   = prod_sext;
              acc_sat_d   = 1'b0;
              acc_valid_d = 1'b1;
            end else begin
              state_d = ACCUM;
              acc_d   = prod_sext;
              cnt_d   = 8'd1;
              sat_d   = 1'b0;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            if (cnt_inc == COUNT_L) begin
              // Publish the final sum and scrub the working accumulator for the next block.
              state_d     = DONE;
              acc_out_d   = sum_sat;
              acc_sat_d   = sat_q | sum_ovf;
              acc_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              sat_d       = 1'b0;
            end else begin
              acc_d = sum_sat;
              cnt_d = cnt_inc;
              sat_d = sat_q | sum_ovf;
            end
          end
        end
        DONE: begin
          if (acc_ready) begin
            state_d     = IDLE;
            acc_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      acc_out_q   <= '0;
      acc_sat_q   <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      acc_out_q   <= acc_out_d;
      acc_sat_q   <= acc_sat_d;
      acc_valid_q <= acc_valid_d;
    end
  end

endmodule
